// File: rtl/spu32_cpu_mulseq_if.sv
// Request/response bus between the execute FSM and the multiply sequencer,
// plus the sequencer's launch/return bus to the multi-cycle multiplier.
interface spu32_cpu_mulseq_if;
  logic        I_en;
  logic [3:0]  I_op;
  logic [31:0] I_s1;
  logic [31:0] I_s2;
  logic [31:0] O_result;
  logic        O_busy;
  logic        O_done;
  logic        O_mul_en;
  logic [3:0]  O_mul_op;
  logic [31:0] O_mul_s1;
  logic [31:0] O_mul_s2;
  logic [63:0] I_mul_result;
  logic        I_mul_busy;

  modport slave (
    input  I_en, I_op, I_s1, I_s2, I_mul_result, I_mul_busy,
    output O_result, O_busy, O_done, O_mul_en, O_mul_op, O_mul_s1, O_mul_s2
  );

  modport master (
    output I_en, I_op, I_s1, I_s2, I_mul_result, I_mul_busy,
    input  O_result, O_busy, O_done, O_mul_en, O_mul_op, O_mul_s1, O_mul_s2
  );
endinterface

// File: rtl/spu32_cpu_mulseq.sv
// Multiply sequencer: launches the multi-cycle multiplier with a one-cycle
// enable, selects the architectural half and caches the last product.
module spu32_cpu_mulseq #(
  parameter int unsigned CACHE_EN = 1
) (
  input logic               I_clk,
  input logic               I_reset,
  spu32_cpu_mulseq_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam logic [OPW-1:0] ALUOP_MUL    = 4'b1010;
  localparam logic [OPW-1:0] ALUOP_MULH   = 4'b1011;
  localparam logic [OPW-1:0] ALUOP_MULHSU = 4'b1100;
  localparam logic [OPW-1:0] ALUOP_MULHU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [2*XLEN-1:0] product_q, product_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, mul_en_q, mul_en_d;
  logic              c_valid_q, c_valid_d, c_lo_only_q, c_lo_only_d;
  logic [XLEN-1:0]   c_s1_q, c_s1_d, c_s2_q, c_s2_d;
  logic [OPW-1:0]    c_kind_q, c_kind_d;

  logic is_mul_op_c, accept_c, hit_c;

  function automatic logic [XLEN-1:0] sel_half(input logic [2*XLEN-1:0] p,
                                               input logic [OPW-1:0] op);
    return (op == ALUOP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign is_mul_op_c = (bus.I_op == ALUOP_MUL) || (bus.I_op == ALUOP_MULH) ||
                       (bus.I_op == ALUOP_MULHSU) || (bus.I_op == ALUOP_MULHU);
  assign accept_c    = (state_q == S_IDLE) && bus.I_en && is_mul_op_c;

  // Low word is signedness-independent, so MUL may reuse any cached product.
  assign hit_c = (CACHE_EN != 0) && c_valid_q &&
                 (bus.I_s1 == c_s1_q) && (bus.I_s2 == c_s2_q) &&
                 ((bus.I_op == ALUOP_MUL) || (!c_lo_only_q && (c_kind_q == bus.I_op)));

  always_ff @(posedge I_clk) begin
    if (I_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = hit_c ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (!bus.I_mul_busy) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    product_d   = product_q;
    result_d    = result_q;
    c_valid_d   = c_valid_q;
    c_s1_d      = c_s1_q;
    c_s2_d      = c_s2_q;
    c_lo_only_d = c_lo_only_q;
    c_kind_d    = c_kind_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mul_en_d    = (state_d == S_LAUNCH);
    if (accept_c) begin
      op_d = bus.I_op;
      s1_d = bus.I_s1;
      s2_d = bus.I_s2;
      if (hit_c) result_d = sel_half(product_q, bus.I_op);
    end
    if ((state_q == S_WAIT) && !bus.I_mul_busy) begin
      product_d   = bus.I_mul_result;
      result_d    = sel_half(bus.I_mul_result, op_q);
      c_valid_d   = 1'b1;
      c_s1_d      = s1_q;
      c_s2_d      = s2_q;
      c_lo_only_d = (op_q == ALUOP_MUL);
      c_kind_d    = op_q;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      op_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      product_q   <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      c_valid_q   <= 1'b0;
      c_s1_q      <= '0;
      c_s2_q      <= '0;
      c_lo_only_q <= 1'b0;
      c_kind_q    <= '0;
    end else begin
      op_q        <= op_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      product_q   <= product_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mul_en_q    <= mul_en_d;
      c_valid_q   <= c_valid_d;
      c_s1_q      <= c_s1_d;
      c_s2_q      <= c_s2_d;
      c_lo_only_q <= c_lo_only_d;
      c_kind_q    <= c_kind_d;
    end
  end

  assign bus.O_result = result_q;
  assign bus.O_busy   = busy_q;
  assign bus.O_done   = done_q;
  assign bus.O_mul_en = mul_en_q;
  assign bus.O_mul_op = op_q;
  assign bus.O_mul_s1 = s1_q;
  assign bus.O_mul_s2 = s2_q;
endmodule

// File: tb/tb_spu32_cpu_mulseq.sv
// Bench for spu32_cpu_mulseq: behavioural multiplier stub, transaction-level
// timing/cache model, per-cycle output comparison and literal result pins.
module tb_spu32_cpu_mulseq;
  localparam logic [3:0] ALUOP_ADD    = 4'b0000;
  localparam logic [3:0] ALUOP_MUL    = 4'b1010;
  localparam logic [3:0] ALUOP_MULH   = 4'b1011;
  localparam logic [3:0] ALUOP_MULHSU = 4'b1100;
  localparam logic [3:0] ALUOP_MULHU  = 4'b1101;
  localparam bit         CACHE_ON     = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  spu32_cpu_mulseq_if bus();

  spu32_cpu_mulseq #(.CACHE_EN(1)) dut (
    .I_clk   (clk),
    .I_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Full 64-bit product as the M extension defines it for each opcode.
  function automatic logic [63:0] full_prod(input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      ALUOP_MULHU:  return ua * ub;
      ALUOP_MULHSU: return 64'(sa * $signed(ub));
      default:      return 64'(sa * sb);
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = full_prod(op, a, b);
    return (op == ALUOP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier stub: busy for mul_lat cycles after each enable.
  int          mul_lat = 1;
  int          mcnt = 0;
  logic [63:0] mres = '0;
  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      mres <= '0;
    end else if (bus.O_mul_en) begin
      mcnt <= mul_lat;
      mres <= full_prod(bus.O_mul_op, bus.O_mul_s1, bus.O_mul_s2);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign bus.I_mul_busy   = (mcnt != 0);
  assign bus.I_mul_result = mres;

  // Transaction-level model: cycle numbers of busy/launch/done plus result.
  int          m_busy_from = 0;
  int          m_done_at   = -1;
  int          m_en_at     = -1;
  logic [31:0] m_pending   = '0;
  logic [31:0] m_result    = '0;
  bit          c_valid = 1'b0, c_lo = 1'b0;
  logic [31:0] c_s1 = '0, c_s2 = '0;
  logic [3:0]  c_kind = '0;
  int          exp_launch = 0;
  int          n_launch   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == m_done_at) m_result = m_pending;
      if (bus.O_mul_en) n_launch++;
      check("busy",   64'(bus.O_busy),   64'((cyc >= m_busy_from) && (cyc <= m_done_at)));
      check("done",   64'(bus.O_done),   64'(cyc == m_done_at));
      check("mul_en", 64'(bus.O_mul_en), 64'(cyc == m_en_at));
      check("result", 64'(bus.O_result), 64'(m_result));
    end
  end

  task automatic clear_model();
    m_done_at = -1;
    m_en_at   = -1;
    m_result  = '0;
    c_valid   = 1'b0;
  endtask

  // Reset is asserted in the current cycle; the model clears once the edge has applied it.
  task automatic reset_cycles(input int n);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_model();
    repeat (n - 1) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic start_req(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
    bit hit;
    mul_lat  = lat;
    bus.I_en = 1'b1;
    bus.I_op = op;
    bus.I_s1 = a;
    bus.I_s2 = b;
    hit = CACHE_ON && c_valid && (a == c_s1) && (b == c_s2) &&
          ((op == ALUOP_MUL) || (!c_lo && (c_kind == op)));
    m_busy_from = cyc + 1;
    m_pending   = ref_res(op, a, b);
    if (hit) begin
      m_en_at   = -1;
      m_done_at = cyc + 1;
    end else begin
      m_en_at   = cyc + 1;
      m_done_at = cyc + 3 + lat;
      exp_launch++;
      c_valid = 1'b1;
      c_s1    = a;
      c_s2    = b;
      c_lo    = (op == ALUOP_MUL);
      c_kind  = op;
    end
    @(posedge clk); #1;
    bus.I_en = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= m_done_at) begin @(posedge clk); #1; end
  endtask

  task automatic run_req(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat);
    start_req(op, a, b, lat);
    wait_done();
  endtask

  initial begin
    bus.I_en = 1'b0;
    bus.I_op = ALUOP_ADD;
    bus.I_s1 = '0;
    bus.I_s2 = '0;
    @(posedge clk); #1;
    reset_cycles(2);
    chk_en = 1'b1;
    check("rst_busy",   64'(bus.O_busy),   64'(0));
    check("rst_done",   64'(bus.O_done),   64'(0));
    check("rst_mul_en", 64'(bus.O_mul_en), 64'(0));
    check("rst_result", 64'(bus.O_result), 64'(0));

    run_req(ALUOP_MUL, 32'd3, 32'd5, 2);
    check("mul_3x5", 64'(bus.O_result), 64'(32'd15));

    run_req(ALUOP_MULH, 32'hF4321000, 32'hF0001234, 3);
    check("mulh_signed", 64'(bus.O_result), 64'(32'h00BCDE29));

    // Non-multiply opcode with I_en set must be ignored.
    bus.I_en = 1'b1;
    bus.I_op = ALUOP_ADD;
    repeat (3) begin @(posedge clk); #1; end
    bus.I_en = 1'b0;

    run_req(ALUOP_MULHU, 32'h07654321, 32'h01234567, 4);
    run_req(ALUOP_MUL,   32'h07654321, 32'h01234567, 4);

    run_req(ALUOP_MUL,    32'hFFFFFFFF, 32'h00000003, 1);
    check("mul_lo", 64'(bus.O_result), 64'(32'hFFFFFFFD));
    run_req(ALUOP_MULHSU, 32'hFFFFFFFF, 32'h00000003, 1);
    check("mulhsu_hi", 64'(bus.O_result), 64'(32'hFFFFFFFF));

    run_req(ALUOP_MULHU, 32'h80000000, 32'h80000000, 0);
    check("mulhu_zero_lat", 64'(bus.O_result), 64'(32'h40000000));
    run_req(ALUOP_MULHU, 32'h80000000, 32'h80000000, 0);

    // Reset in the third WAIT cycle of a MULH, then repeat it.
    start_req(ALUOP_MULH, 32'h12345678, 32'h9ABCDEF0, 5);
    repeat (3) begin @(posedge clk); #1; end
    reset_cycles(1);
    repeat (2) begin @(posedge clk); #1; end
    run_req(ALUOP_MULH, 32'h12345678, 32'h9ABCDEF0, 2);

    // Request coincident with reset is dropped.
    bus.I_en = 1'b1;
    bus.I_op = ALUOP_MUL;
    bus.I_s1 = 32'd7;
    bus.I_s2 = 32'd9;
    reset_cycles(1);
    bus.I_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    run_req(ALUOP_MUL, 32'd7, 32'd9, 1);
    check("mul_after_rst", 64'(bus.O_result), 64'(32'd63));
    repeat (2) begin @(posedge clk); #1; end
    check("launch_count", 64'(n_launch), 64'(exp_launch));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
